gray_cnt_rx: RTL and testbench
==============================

// Module: gray_cnt_rx
// PURPOSE
// - Receive end of a gray-coded cross-domain event counter. Samples a free-running gray count from a foreign
//   clock domain, synchronises and decodes it, and presents each increment as one valid/ready event locally.
// - Sits in the consumer domain; the producer only asserts inc. Single clock; no producer-side logic here.
// PARAMETERS
// - W      default 8  count width; at most 2**W-1 unconsumed events allowed (system constraint, not detected)
// - SYNC   default 2  synchroniser flop stages on gray_in (legal >= 2)
// PORTS
// - clk_b     in   1     consumer clock; one clock, all flops on posedge clk_b
// - rst_b     in   1     reset, synchronous, active-high
// - gray_in   in   W     producer gray count (asynchronous to clk_b, changes <= 1 bit per producer edge)
// - flush     in   1     discard all pending events
// - ev_ready  in   1     downstream accepts current event
// - ev_valid  out  1     >= 1 event pending
// - ev_seq    out  W     sequence number of current event (= consumed count cnt_rd)
// - pending   out  W     cnt_seen - cnt_rd, mod 2**W
// - rdy       out  1     block aligned and in RUN
// - err       out  1     sticky illegal gray transition (see CONFIGURATION)
// BEHAVIOUR
// - Sync: gray_sync[0] <= gray_in, gray_sync[i] <= gray_sync[i-1]; cnt_seen <= gray2bin(gray_sync[SYNC-1]),
//   gray2bin bit i = XOR of gray bits W-1..i. gray_in change reaches cnt_seen after SYNC+1 clk_b edges.
// - On rst_b: sync chain, cnt_seen, cnt_rd, init counter = 0; state INIT; ev_valid=0, ev_seq=0, pending=0,
//   rdy=0, err=0. Reset mid-operation aborts everything; outstanding events are not reported.
// - FSM: INIT -> ALIGN -> RUN; RUN is terminal until reset.
//   - INIT: counts SYNC+1 edges (chain + cnt_seen filled), then ALIGN. ev_valid=0; ev_ready, flush ignored.
//   - ALIGN: one cycle; cnt_rd <= cnt_seen (no burst of stale events after reset); -> RUN.
//   - RUN: rdy=1; normal operation. rdy=1 after SYNC+2 edges with rst_b low.
// - pending = cnt_seen - cnt_rd, W-bit wrap arithmetic, combinational from registers.
// - ev_valid = RUN && pending != 0; ev_seq = cnt_rd. Once high, ev_valid stays high until its handshake.
// - Handshake: ev_valid && ev_ready at edge -> cnt_rd <= cnt_rd + 1 (wraps 2**W-1 -> 0). One event/cycle max;
//   ev_ready with ev_valid=0 has no effect. Back-to-back accepts allowed.
// - flush in RUN: cnt_rd <= cnt_seen (registered value at that edge); priority over handshake; simultaneous
//   flush+accept -> no extra increment. Events arriving in cnt_seen at that same edge remain pending.
// - Simultaneous cnt_seen advance and accept: pending unchanged net; no event lost or duplicated.
// CONFIGURATION
// - Macro GRAY_CNT_RX_CHECK_EN:
//   - defined: register gray_prev <= gray_sync[SYNC-1] every cycle; in RUN, if popcount(gray_prev ^
//     gray_sync[SYNC-1]) > 1 -> err <= 1 next edge, sticky until rst_b. Detection only; counting unaffected.
//   - undefined: no gray_prev, no check logic; err tied 0.
// TESTING
// - Reset, gray_in=0 held -> rdy=0 for SYNC+1 edges, rdy=1 after SYNC+2 edges; ev_valid=0, pending=0.
// - Reset with gray_in=gray(5)=0x07 held -> after rdy: pending=0, ev_valid=0, ev_seq=5 (no stale burst).
// - RUN, gray_in 0x07->0x05->0x04 (5,6,7) one per cycle, ev_ready=0 -> pending=2 SYNC+1 edges after last
//   step, ev_valid=1, ev_seq=5; ev_ready=1 two cycles -> seq 5,6 accepted, pending=0, ev_valid=0.
// - W=8, cnt_rd=255, cnt_seen=0 (pending=1) -> accept -> ev_seq=0, pending=0 (wrap).
// - pending=3, flush=1 and ev_ready=1 same edge -> next cycle pending=0, ev_seq=cnt_seen, single update only.
// - With GRAY_CNT_RX_CHECK_EN, in RUN gray_in 0x00->0x03 -> err=1 within SYNC+2 edges, stays 1 until rst_b;
//   without macro same stimulus -> err=0.

Source files
------------

// File: rtl/gray_cnt_rx.sv
// Consumer-side receiver for a gray-coded cross-domain event counter: synchronises, decodes and
// presents each increment as a valid/ready event. Optional macro GRAY_CNT_RX_CHECK_EN adds a sticky illegal-transition flag.
module gray_cnt_rx #(
  parameter int W    = 8,
  parameter int SYNC = 2
) (
  input  logic         clk_b,
  input  logic         rst_b,
  input  logic [W-1:0] gray_in,
  input  logic         flush,
  input  logic         ev_ready,
  output logic         ev_valid,
  output logic [W-1:0] ev_seq,
  output logic [W-1:0] pending,
  output logic         rdy,
  output logic         err
);

  localparam int CW = $clog2(SYNC + 2);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_ALIGN = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_init_cnt;
  logic [W-1:0]  r_gray_sync [SYNC];
  logic [W-1:0]  r_cnt_seen;
  logic [W-1:0]  r_cnt_rd;
  logic          w_run;
  logic          w_accept;

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b        = '0;
    b[W-1]   = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Synchroniser chain followed by the registered binary decode
  always_ff @(posedge clk_b) begin
    if (rst_b) begin
      for (int i = 0; i < SYNC; i++) begin
        r_gray_sync[i] <= '0;
      end
      r_cnt_seen <= '0;
    end else begin
      r_gray_sync[0] <= gray_in;
      for (int i = 1; i < SYNC; i++) begin
        r_gray_sync[i] <= r_gray_sync[i-1];
      end
      r_cnt_seen <= gray2bin(r_gray_sync[SYNC-1]);
    end
  end

  always_ff @(posedge clk_b) begin
    if (rst_b) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) begin
        r_init_cnt <= r_init_cnt + 1'b1;
      end
    end
  end

  // INIT waits until the chain and cnt_seen hold real samples
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  if (r_init_cnt == CW'(SYNC)) w_state_nxt = S_ALIGN;
      S_ALIGN: w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    w_run    = (r_state == S_RUN);
    rdy      = w_run;
    pending  = r_cnt_seen - r_cnt_rd;
    ev_valid = w_run && (pending != '0);
    ev_seq   = r_cnt_rd;
    w_accept = ev_valid && ev_ready;
  end

  // Alignment and flush both snap the read pointer to the registered seen count
  always_ff @(posedge clk_b) begin
    if (rst_b) begin
      r_cnt_rd <= '0;
    end else if (r_state == S_ALIGN) begin
      r_cnt_rd <= r_cnt_seen;
    end else if (w_run && flush) begin
      r_cnt_rd <= r_cnt_seen;
    end else if (w_accept) begin
      r_cnt_rd <= r_cnt_rd + 1'b1;
    end
  end

`ifdef GRAY_CNT_RX_CHECK_EN
  logic [W-1:0] r_gray_prev;
  logic         r_err;

  function automatic int unsigned popcnt(input logic [W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < W; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

  always_ff @(posedge clk_b) begin
    if (rst_b) begin
      r_gray_prev <= '0;
      r_err       <= 1'b0;
    end else begin
      r_gray_prev <= r_gray_sync[SYNC-1];
      if (w_run && (popcnt(r_gray_prev ^ r_gray_sync[SYNC-1]) > 1)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_cnt_rx.sv
// Scoreboard bench for gray_cnt_rx: expected event sequence numbers are queued as gray steps are driven
// and popped as the DUT hands events over.
module tb_gray_cnt_rx;

  localparam int W    = 8;
  localparam int SYNC = 2;

  logic         clk_b = 1'b0;
  logic         rst_b = 1'b1;
  logic [W-1:0] gray_in = '0;
  logic         flush = 1'b0;
  logic         ev_ready = 1'b0;
  logic         ev_valid;
  logic [W-1:0] ev_seq;
  logic [W-1:0] pending;
  logic         rdy;
  logic         err;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q [$];
  logic [W-1:0] m_seen;
  logic [W-1:0] exp_seq;
  logic         exp_err;

  gray_cnt_rx #(.W(W), .SYNC(SYNC)) dut (
    .clk_b    (clk_b),
    .rst_b    (rst_b),
    .gray_in  (gray_in),
    .flush    (flush),
    .ev_ready (ev_ready),
    .ev_valid (ev_valid),
    .ev_seq   (ev_seq),
    .pending  (pending),
    .rdy      (rdy),
    .err      (err)
  );

  always #5 clk_b = ~clk_b;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk_b);
    #1;
  endtask

  task automatic do_reset(input logic [W-1:0] start);
    rst_b    = 1'b1;
    flush    = 1'b0;
    ev_ready = 1'b0;
    m_seen   = start;
    gray_in  = bin2gray(start);
    exp_q.delete();
    tick();
    rst_b = 1'b0;
  endtask

  // One producer increment: queue its sequence number, move gray_in by one bit
  task automatic step();
    exp_q.push_back(m_seen);
    m_seen  = m_seen + 1'b1;
    gray_in = bin2gray(m_seen);
  endtask

  task automatic wait_rdy();
    int n;
    n = 0;
    while (rdy !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL wait_rdy: rdy=%b want 1 within 16 cycles", rdy);
    end
  endtask

  task automatic test_reset();
    do_reset('0);
    checks++;
    if (rdy !== 1'b0 || ev_valid !== 1'b0 || pending !== '0 || ev_seq !== '0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b ev_valid=%b pending=%0d ev_seq=%0d err=%b want all 0",
               rdy, ev_valid, pending, ev_seq, err);
    end
    for (int k = 1; k <= SYNC + 1; k++) begin
      tick();
      checks++;
      if (rdy !== 1'b0) begin
        errors++;
        $display("FAIL reset_rdy_low edge %0d: rdy=%b want 0", k, rdy);
      end
    end
    tick();
    checks++;
    if (rdy !== 1'b1 || ev_valid !== 1'b0 || pending !== '0) begin
      errors++;
      $display("FAIL reset_rdy_high: rdy=%b ev_valid=%b pending=%0d want 1 0 0", rdy, ev_valid, pending);
    end
  endtask

  task automatic test_no_stale();
    do_reset(8'd5);
    wait_rdy();
    checks++;
    if (pending !== '0 || ev_valid !== 1'b0 || ev_seq !== 8'd5) begin
      errors++;
      $display("FAIL no_stale: pending=%0d ev_valid=%b ev_seq=%0d want 0 0 5", pending, ev_valid, ev_seq);
    end
  endtask

  task automatic test_stream();
    int n;
    step();
    tick();
    step();
    for (int k = 0; k < SYNC + 1; k++) tick();
    checks++;
    if (pending !== 8'd2 || ev_valid !== 1'b1 || ev_seq !== 8'd5) begin
      errors++;
      $display("FAIL stream_pending: pending=%0d ev_valid=%b ev_seq=%0d want 2 1 5", pending, ev_valid, ev_seq);
    end
    ev_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 8) begin
      exp_seq = exp_q.pop_front();
      checks++;
      if (ev_valid !== 1'b1 || ev_seq !== exp_seq) begin
        errors++;
        $display("FAIL stream_accept: ev_valid=%b ev_seq=%0d want 1 %0d", ev_valid, ev_seq, exp_seq);
      end
      tick();
      n++;
    end
    ev_ready = 1'b0;
    checks++;
    if (pending !== '0 || ev_valid !== 1'b0 || ev_seq !== 8'd7) begin
      errors++;
      $display("FAIL stream_drained: pending=%0d ev_valid=%b ev_seq=%0d want 0 0 7", pending, ev_valid, ev_seq);
    end
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    checks++;
    if (ev_seq !== 8'd7 || pending !== '0) begin
      errors++;
      $display("FAIL ready_no_valid: ev_seq=%0d pending=%0d want 7 0", ev_seq, pending);
    end
  endtask

  task automatic test_wrap();
    do_reset(8'd255);
    wait_rdy();
    step();
    for (int k = 0; k < SYNC + 1; k++) tick();
    checks++;
    if (pending !== 8'd1 || ev_valid !== 1'b1 || ev_seq !== 8'd255) begin
      errors++;
      $display("FAIL wrap_pending: pending=%0d ev_valid=%b ev_seq=%0d want 1 1 255", pending, ev_valid, ev_seq);
    end
    ev_ready = 1'b1;
    exp_seq  = exp_q.pop_front();
    tick();
    ev_ready = 1'b0;
    checks++;
    if (ev_seq !== 8'd0 || pending !== '0 || ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_accept: ev_seq=%0d pending=%0d ev_valid=%b want 0 0 0", ev_seq, pending, ev_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      if (i < 12) step();
      ev_ready = (i < 6) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      if (ev_valid === 1'b1 && ev_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_duplicate: ev_seq=%0d offered with no event outstanding", ev_seq);
        end else begin
          exp_seq = exp_q.pop_front();
          if (ev_seq !== exp_seq) begin
            errors++;
            $display("FAIL b2b_seq: ev_seq=%0d want %0d", ev_seq, exp_seq);
          end
        end
      end
      tick();
    end
    ev_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || pending !== '0 || ev_seq !== m_seen || err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_final: left=%0d pending=%0d ev_seq=%0d err=%b want 0 0 %0d 0",
               exp_q.size(), pending, ev_seq, err, m_seen);
    end
  endtask

  task automatic test_flush();
    step();
    tick();
    step();
    tick();
    step();
    for (int k = 0; k < SYNC + 1; k++) tick();
    checks++;
    if (pending !== 8'd3) begin
      errors++;
      $display("FAIL flush_setup: pending=%0d want 3", pending);
    end
    flush    = 1'b1;
    ev_ready = 1'b1;
    tick();
    flush    = 1'b0;
    ev_ready = 1'b0;
    exp_q.delete();
    checks++;
    if (pending !== '0 || ev_valid !== 1'b0 || ev_seq !== m_seen) begin
      errors++;
      $display("FAIL flush_accept: pending=%0d ev_valid=%b ev_seq=%0d want 0 0 %0d", pending, ev_valid, ev_seq, m_seen);
    end
    // Event landing in cnt_seen on the flush edge must survive
    step();
    for (int k = 0; k < SYNC; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (pending !== 8'd1 || ev_valid !== 1'b1 || ev_seq !== exp_q[0]) begin
      errors++;
      $display("FAIL flush_inflight: pending=%0d ev_valid=%b ev_seq=%0d want 1 1 %0d", pending, ev_valid, ev_seq, exp_q[0]);
    end
    ev_ready = 1'b1;
    exp_seq  = exp_q.pop_front();
    tick();
    ev_ready = 1'b0;
    checks++;
    if (pending !== '0 || ev_seq !== m_seen) begin
      errors++;
      $display("FAIL flush_drain: pending=%0d ev_seq=%0d want 0 %0d", pending, ev_seq, m_seen);
    end
  endtask

  task automatic test_err();
`ifdef GRAY_CNT_RX_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset('0);
    wait_rdy();
    gray_in = 8'h03;
    for (int k = 0; k < SYNC + 2; k++) tick();
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL err_set: err=%b want %b", err, exp_err);
    end
    gray_in = 8'h02;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL err_sticky: err=%b want %b", err, exp_err);
    end
    do_reset('0);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_reset: err=%b want 0", err);
    end
  endtask

  initial begin
    test_reset();
    test_no_stale();
    test_stream();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
